apb_rr_requester: RTL
=====================

// Module: apb_rr_requester
// PURPOSE
//  APB requester (master-side controller) that shares one APB bus among NREQ local requesters.
//  - Arbitrates round-robin and captures the winning request.
//  - Decodes the address to one of NSLV one-hot psel lines.
//  - Sequences IDLE/SETUP/ACCESS with wait states and a timeout, then returns one response per transfer.
//  - Sits between CPU/DMA-style requesters and the apb_slave/storage array.
// PARAMETERS
//  NREQ     2   number of requesters (>=2)
//  NSLV     4   number of APB completers; psel width
//  SEL_LSB  8   paddr bit where the 2-bit slave index starts (slave = paddr[SEL_LSB+:2])
//  TIMEOUT  16  max ACCESS cycles before abort; counter width $clog2(TIMEOUT+1)
// PORTS
//  pclk       in   1        clock, rising edge
//  preset     in   1        asynchronous, active-low reset
//  req_valid  in   NREQ     request pending; hold it and its fields stable until req_ready
//  req_addr   in   NREQ*32  flattened addresses, requester i at [32*i+:32]
//  req_write  in   NREQ     1=write, 0=read
//  req_wdata  in   NREQ*32  flattened write data
//  req_strb   in   NREQ*4   flattened byte strobes
//  req_prot   in   NREQ*3   flattened pprot
//  req_ready  out  NREQ     one-hot accept pulse; fields are captured on this edge
//  rsp_valid  out  NREQ     one-hot response pulse, one cycle
//  rsp_rdata  out  32       read data, 0 for writes and errors
//  rsp_err    out  1        pslverr, decode error or timeout; valid with rsp_valid
//  paddr,pwrite,pprot,pwdata,pstrb  out  32,1,3,32,4  registered APB request fields
//  psel       out  NSLV     one-hot select
//  penable    out  1        ACCESS-phase marker
//  prdata     in   32       OR/mux of completer read data
//  pready     in   1        completer ready
//  pslverr    in   1        completer error, sampled only when pready=1 in ACCESS
// BEHAVIOUR
//  Reset: all outputs are 0, state=IDLE, rr pointer=0, timeout counter=0.
//  - preset low mid-transfer drops psel/penable immediately.
//  - No response is issued for the aborted transfer.
//  Arbitration:
//  - Evaluated in IDLE, and in ACCESS on the completion cycle.
//  - Search starts at pointer p and picks the first set req_valid bit at or after p.
//  - req_ready[winner]=1 combinationally in that cycle; pointer becomes winner+1 mod NREQ.
//  Decode: idx=addr[SEL_LSB+:2]. Any addr bit above SEL_LSB+1 set, or idx>=NSLV, is a decode error.
//  FSM:
//  - IDLE: if there is a grant -> SETUP, or DERR on a decode error.
//  - SETUP (1 cycle): psel[idx]=1, penable=0 -> ACCESS.
//  - ACCESS: psel=1, penable=1; the counter increments each cycle pready=0.
//    - pready=1: complete. Capture prdata (reads) and pslverr.
//      -> SETUP if a new grant exists (back-to-back, psel held), else -> IDLE.
//    - counter==TIMEOUT-1 with pready=0: abort, rsp_err=1, rdata=0, psel/penable=0 next cycle -> IDLE.
//  - DERR (1 cycle): no psel. Respond with rsp_err=1, rdata=0 -> IDLE.
//  Response:
//  - rsp_valid[owner] pulses the cycle after completion, abort or DERR.
//  - Responses are registered and never overlap; at most one transfer is outstanding.
//  Timing and bus rules:
//  - Latency: accept at t, SETUP t+1, ACCESS t+2, pready=1 at t+2 -> rsp_valid at t+3.
//  - APB fields change only on entering SETUP. penable is never 1 without psel.
//  - pready outside ACCESS is ignored.
//  - req_valid dropped before req_ready is allowed; the request is not sampled.
// STRUCTURE
//  apb_pkg: state enum, TIMEOUT/SEL_LSB defaults, PPROT_* constants, helper function onehot(idx).
//  Sub-module apb_rr_arbiter (NREQ): req vector + advance -> one-hot grant, pointer register.
//  The top level holds the FSM, capture registers, decoder, timeout counter and response regs.
// TESTING
//  1. Single write, req0 addr=0x104 data=0xA5A5_0001 strb=0xF, pready=1 at first ACCESS
//     -> psel=4'b0010; rsp_valid[0] at t+3; rsp_err=0.
//  2. Read back 0x104 with pready low 3 cycles, prdata=0xA5A5_0001
//     -> penable held 4 cycles; rsp_rdata=0xA5A5_0001.
//  3. req0 and req1 held valid continuously
//     -> grants alternate 0,1,0,1; back-to-back SETUP with no IDLE gap.
//  4. addr=0x400 (bit10 set) -> no psel; rsp_err=1 at t+2; rdata=0.
//  5. pready stuck 0 -> abort after 16 ACCESS cycles; rsp_err=1; next request is served normally.
//  6. preset low during ACCESS -> psel/penable/rsp_valid=0 at once; pointer=0 after release.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the round-robin APB requester.
// Holds the FSM state encoding, default timing parameters and the psel one-hot helper.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DERR
    } state_t;

    localparam int TIMEOUT_DEF = 16;
    localparam int SEL_LSB_DEF = 8;

    localparam logic [2:0] PPROT_PRIV   = 3'b001;
    localparam logic [2:0] PPROT_NONSEC = 3'b010;
    localparam logic [2:0] PPROT_INSTR  = 3'b100;

    // The slave index is two bits wide, so at most four select lines exist.
    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// and moves the pointer past the winner whenever a grant is taken.
module apb_rr_arbiter
    import apb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic            pclk,
    input  logic            preset,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic            any
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic [PW-1:0] j;

    always_comb begin
        grant    = '0;
        any      = 1'b0;
        ptr_next = ptr;
        j        = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = PW'((int'(ptr) + k) % NREQ);
            if (!any && req[j]) begin
                grant[j] = 1'b1;
                any      = 1'b1;
                ptr_next = (int'(j) == NREQ - 1) ? '0 : j + 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            ptr <= '0;
        end else if (advance && any) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/apb_rr_requester.sv
// APB requester sharing one bus among NREQ local requesters: round-robin grant,
// address decode to psel, SETUP/ACCESS sequencing with timeout, one response per transfer.
module apb_rr_requester
    import apb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int NSLV    = 4,
    parameter int SEL_LSB = SEL_LSB_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               pclk,
    input  logic               preset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*32-1:0] req_addr,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*32-1:0] req_wdata,
    input  logic [NREQ*4-1:0]  req_strb,
    input  logic [NREQ*3-1:0]  req_prot,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err,
    output logic [31:0]        paddr,
    output logic               pwrite,
    output logic [2:0]         pprot,
    output logic [31:0]        pwdata,
    output logic [3:0]         pstrb,
    output logic [NSLV-1:0]    psel,
    output logic               penable,
    input  logic [31:0]        prdata,
    input  logic               pready,
    input  logic               pslverr
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          state;
    state_t          state_next;
    logic [NREQ-1:0] grant;
    logic            any;
    logic            arb_en;
    logic            accept;
    logic            done;
    logic            abort;
    logic [31:0]     sel_addr;
    logic [31:0]     sel_wdata;
    logic            sel_write;
    logic [3:0]      sel_strb;
    logic [2:0]      sel_prot;
    logic [1:0]      sel_idx;
    logic            sel_derr;
    logic [NREQ-1:0] owner;
    logic            cur_write;
    logic [CW-1:0]   cnt;

    apb_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .pclk    (pclk),
        .preset  (preset),
        .req     (req_valid),
        .advance (arb_en),
        .grant   (grant),
        .any     (any)
    );

    // Arbitration happens only while the bus is free or the current transfer is finishing.
    assign arb_en    = (state == ST_IDLE) || (state == ST_ACCESS && pready);
    assign accept    = arb_en && any;
    assign req_ready = arb_en ? grant : '0;
    assign done      = (state == ST_ACCESS) && pready;
    assign abort     = (state == ST_ACCESS) && !pready && (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        sel_strb  = '0;
        sel_prot  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr  = req_addr[32*i +: 32];
                sel_wdata = req_wdata[32*i +: 32];
                sel_write = req_write[i];
                sel_strb  = req_strb[4*i +: 4];
                sel_prot  = req_prot[3*i +: 3];
            end
        end
    end

    assign sel_idx  = sel_addr[SEL_LSB +: 2];
    assign sel_derr = (|(sel_addr >> (SEL_LSB + 2))) || (int'(sel_idx) >= NSLV);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_next = sel_derr ? ST_DERR : ST_SETUP;
            end
            ST_SETUP: state_next = ST_ACCESS;
            ST_ACCESS: begin
                if (pready) begin
                    if (accept) state_next = sel_derr ? ST_DERR : ST_SETUP;
                    else        state_next = ST_IDLE;
                end else if (abort) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DERR: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            owner     <= '0;
            cur_write <= 1'b0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pprot     <= '0;
            pwdata    <= '0;
            pstrb     <= '0;
            psel      <= '0;
            penable   <= 1'b0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= (state == ST_ACCESS && state_next == ST_ACCESS) ? cnt + 1'b1 : '0;
            if (accept) begin
                owner     <= grant;
                cur_write <= sel_write;
            end
            // Bus fields only move when a decoded transfer enters SETUP.
            if (state_next == ST_SETUP) begin
                paddr  <= sel_addr;
                pwrite <= sel_write;
                pprot  <= sel_prot;
                pwdata <= sel_wdata;
                pstrb  <= sel_strb;
                psel   <= NSLV'(onehot(sel_idx));
            end else if (state_next != ST_ACCESS) begin
                psel <= '0;
            end
            penable   <= (state_next == ST_ACCESS);
            rsp_valid <= (done || abort || state == ST_DERR) ? owner : '0;
            rsp_err   <= (done && pslverr) || abort || (state == ST_DERR);
            rsp_rdata <= (done && !cur_write && !pslverr) ? prdata : '0;
        end
    end

endmodule
